// File: rtl/slave_in_port.sv
// Serial receive front-end of a bus slave: deserialises an LSB-first address and write data under valid/ready.
// Optional macro SLAVE_IN_PARITY_EN adds an even-parity bit after each data byte and a parity_err pulse.
module slave_in_port #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_address,
   input  logic                  rx_data,
   input  logic                  master_valid,
   input  logic                  master_ready,
   input  logic                  read_en,
   input  logic                  write_en,
   input  logic                  rx_burst,
   output logic                  slave_ready,
   output logic                  rx_done,
   output logic [ADDR_WIDTH-1:0] address,
`ifdef SLAVE_IN_PARITY_EN
   output logic                  parity_err,
`endif
   output logic [DATA_WIDTH-1:0] data
);

   localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CNT_W = $clog2(MAX_W);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DATA,
      DONE,
      WAIT_RD
`ifdef SLAVE_IN_PARITY_EN
      , PARITY
`endif
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_shift;
   logic [DATA_WIDTH-1:0] data_shift;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  is_write;

   // Shift registers fill from the MSB end, so LSB-first bits land in place after a full word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         addr_shift  <= '0;
         data_shift  <= '0;
         bit_cnt     <= '0;
         is_write    <= 1'b0;
         slave_ready <= 1'b1;
         rx_done     <= 1'b0;
         address     <= '0;
         data        <= '0;
`ifdef SLAVE_IN_PARITY_EN
         parity_err  <= 1'b0;
`endif
      end else begin
         rx_done <= 1'b0;
`ifdef SLAVE_IN_PARITY_EN
         parity_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (master_valid && (write_en || read_en)) begin
                  addr_shift  <= {rx_address, addr_shift[ADDR_WIDTH-1:1]};
                  bit_cnt     <= CNT_W'(1);
                  is_write    <= write_en;
                  slave_ready <= 1'b0;
                  state       <= ADDR;
               end
            end
            ADDR: begin
               if (!master_valid) begin
                  slave_ready <= 1'b1;
                  state       <= IDLE;
               end else begin
                  addr_shift <= {rx_address, addr_shift[ADDR_WIDTH-1:1]};
                  if (bit_cnt == ADDR_LAST) begin
                     bit_cnt <= '0;
                     if (is_write) begin
                        state <= DATA;
                     end else begin
                        address <= {rx_address, addr_shift[ADDR_WIDTH-1:1]};
                        rx_done <= 1'b1;
                        state   <= WAIT_RD;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (!master_valid) begin
                  slave_ready <= 1'b1;
                  state       <= IDLE;
               end else begin
                  data_shift <= {rx_data, data_shift[DATA_WIDTH-1:1]};
                  if (bit_cnt == DATA_LAST) begin
`ifdef SLAVE_IN_PARITY_EN
                     state <= PARITY;
`else
                     address <= addr_shift;
                     data    <= {rx_data, data_shift[DATA_WIDTH-1:1]};
                     rx_done <= 1'b1;
                     state   <= DONE;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
`ifdef SLAVE_IN_PARITY_EN
            PARITY: begin
               if (!master_valid) begin
                  slave_ready <= 1'b1;
                  state       <= IDLE;
               end else if (rx_data == ^data_shift) begin
                  address <= addr_shift;
                  data    <= data_shift;
                  rx_done <= 1'b1;
                  state   <= DONE;
               end else begin
                  parity_err  <= 1'b1;
                  slave_ready <= 1'b1;
                  state       <= IDLE;
               end
            end
`endif
            DONE: begin
               // Bursts reuse the assembled address, stepping it so the next byte reports addr+1.
               if (rx_burst && master_valid) begin
                  addr_shift <= addr_shift + 1'b1;
                  bit_cnt    <= '0;
                  state      <= DATA;
               end else begin
                  slave_ready <= 1'b1;
                  state       <= IDLE;
               end
            end
            WAIT_RD: begin
               if (!master_valid || master_ready) begin
                  slave_ready <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               slave_ready <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_slave_in_port.sv
// Directed self-checking bench for slave_in_port; also exercises the parity path when SLAVE_IN_PARITY_EN is defined.
module tb_slave_in_port;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_address;
   logic        rx_data;
   logic        master_valid;
   logic        master_ready;
   logic        read_en;
   logic        write_en;
   logic        rx_burst;
   logic        slave_ready;
   logic        rx_done;
   logic [11:0] address;
   logic [7:0]  data;
`ifdef SLAVE_IN_PARITY_EN
   logic        parity_err;
`endif

   int error_count = 0;
   int check_count = 0;
   int done_count  = 0;

   always #5 clk = ~clk;

   slave_in_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_address   (rx_address),
      .rx_data      (rx_data),
      .master_valid (master_valid),
      .master_ready (master_ready),
      .read_en      (read_en),
      .write_en     (write_en),
      .rx_burst     (rx_burst),
      .slave_ready  (slave_ready),
      .rx_done      (rx_done),
      .address      (address),
`ifdef SLAVE_IN_PARITY_EN
      .parity_err   (parity_err),
`endif
      .data         (data)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      assert (observed === expected) else begin
         error_count++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // One rising edge, then sample 1ns later and tally any rx_done pulse.
   task automatic tick();
      @(posedge clk);
      #1;
      if (rx_done === 1'b1) done_count++;
   endtask

   task automatic applyStimulus(input logic a, input logic d);
      rx_address = a;
      rx_data    = d;
      tick();
   endtask

   task automatic sendAddress(input logic [11:0] addr);
      for (int i = 0; i < 12; i++) applyStimulus(addr[i], 1'b0);
   endtask

   task automatic sendByte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, b[i]);
`ifdef SLAVE_IN_PARITY_EN
      applyStimulus(1'b0, ^b);
`endif
   endtask

   initial begin
      reset = 1'b1; rx_address = 1'b0; rx_data = 1'b0; master_valid = 1'b0;
      master_ready = 1'b0; read_en = 1'b0; write_en = 1'b0; rx_burst = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      checkOutput("reset_ready", slave_ready, 1);
      checkOutput("reset_done", rx_done, 0);
      checkOutput("reset_addr", address, 0);
      checkOutput("reset_data", data, 0);
      reset = 1'b0;
      tick();

      // Single write with every bit one
      master_valid = 1'b1; write_en = 1'b1; rx_address = 1'b1; rx_data = 1'b1;
      done_count = 0;
      tick();
      checkOutput("wr1_busy", slave_ready, 0);
      repeat (18) tick();
      checkOutput("wr1_early_done", done_count, 0);
      tick();
`ifdef SLAVE_IN_PARITY_EN
      rx_data = 1'b0;
      tick();
`endif
      checkOutput("wr1_done", rx_done, 1);
      checkOutput("wr1_addr", address, 12'hFFF);
      checkOutput("wr1_data", data, 8'hFF);
      master_valid = 1'b0; write_en = 1'b0;
      tick();
      checkOutput("wr1_done_drop", rx_done, 0);
      checkOutput("wr1_ready", slave_ready, 1);
      checkOutput("wr1_count", done_count, 1);

      // Patterned write
      master_valid = 1'b1; write_en = 1'b1; done_count = 0;
      sendAddress(12'hA5C);
      checkOutput("wr2_mid_done", done_count, 0);
      sendByte(8'h3C);
      checkOutput("wr2_done", rx_done, 1);
      checkOutput("wr2_addr", address, 12'hA5C);
      checkOutput("wr2_data", data, 8'h3C);
      master_valid = 1'b0; write_en = 1'b0;
      tick();
      checkOutput("wr2_pulse_width", rx_done, 0);
      checkOutput("wr2_ready", slave_ready, 1);

      // Burst across the address wrap
      master_valid = 1'b1; write_en = 1'b1; rx_burst = 1'b1; done_count = 0;
      sendAddress(12'hFFF);
      sendByte(8'h11);
      checkOutput("burst1_done", rx_done, 1);
      checkOutput("burst1_addr", address, 12'hFFF);
      checkOutput("burst1_data", data, 8'h11);
      tick();
      rx_burst = 1'b0;
      checkOutput("burst_gap_ready", slave_ready, 0);
      sendByte(8'h22);
      checkOutput("burst2_done", rx_done, 1);
      checkOutput("burst2_addr", address, 12'h000);
      checkOutput("burst2_data", data, 8'h22);
      master_valid = 1'b0; write_en = 1'b0;
      tick();
      checkOutput("burst_idle", slave_ready, 1);
      checkOutput("burst_count", done_count, 2);

      // Read with delayed master_ready
      master_valid = 1'b1; read_en = 1'b1; master_ready = 1'b0; done_count = 0;
      sendAddress(12'h123);
      checkOutput("rd_done", rx_done, 1);
      checkOutput("rd_addr", address, 12'h123);
      checkOutput("rd_data_kept", data, 8'h22);
      repeat (5) tick();
      checkOutput("rd_wait_ready", slave_ready, 0);
      checkOutput("rd_wait_done", rx_done, 0);
      master_ready = 1'b1;
      tick();
      checkOutput("rd_ready_back", slave_ready, 1);
      checkOutput("rd_count", done_count, 1);
      master_valid = 1'b0; read_en = 1'b0; master_ready = 1'b0;
      tick();

      // Abort after six address bits
      master_valid = 1'b1; write_en = 1'b1; done_count = 0;
      for (int i = 0; i < 6; i++) applyStimulus(i[0], 1'b1);
      master_valid = 1'b0; write_en = 1'b0;
      tick();
      checkOutput("abort_ready", slave_ready, 1);
      repeat (20) tick();
      checkOutput("abort_no_done", done_count, 0);
      checkOutput("abort_addr", address, 12'h123);
      checkOutput("abort_data", data, 8'h22);

      // Read and write together behave as a write
      master_valid = 1'b1; write_en = 1'b1; read_en = 1'b1; done_count = 0;
      sendAddress(12'h0F0);
      sendByte(8'h5A);
      checkOutput("rw_done", rx_done, 1);
      checkOutput("rw_addr", address, 12'h0F0);
      checkOutput("rw_data", data, 8'h5A);
      master_valid = 1'b0; write_en = 1'b0; read_en = 1'b0;
      tick();

`ifdef SLAVE_IN_PARITY_EN
      // Wrong parity bit: 0x01 needs parity 1, send 0
      master_valid = 1'b1; write_en = 1'b1; done_count = 0;
      sendAddress(12'h321);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, (i == 0));
      applyStimulus(1'b0, 1'b0);
      checkOutput("par_err", parity_err, 1);
      checkOutput("par_no_done", done_count, 0);
      checkOutput("par_addr", address, 12'h0F0);
      checkOutput("par_data", data, 8'h5A);
      master_valid = 1'b0; write_en = 1'b0;
      tick();
      checkOutput("par_err_drop", parity_err, 0);
      checkOutput("par_ready", slave_ready, 1);
`endif

      // Reset asserted between edges mid-transfer
      master_valid = 1'b1; write_en = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
      #3 reset = 1'b1;
      #1;
      checkOutput("midrst_ready", slave_ready, 1);
      checkOutput("midrst_done", rx_done, 0);
      checkOutput("midrst_addr", address, 0);
      checkOutput("midrst_data", data, 0);
      master_valid = 1'b0; write_en = 1'b0;
      tick();
      reset = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule
